// File: rtl/vdecode_seq_pkg.sv
// vdec_pkg: shared encodings, state enum and control-word type for the sequenced decoder
package vdec_pkg;
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_AND    = 4'b0010;
  localparam logic [3:0] ALU_ORR    = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0111;
  localparam logic [3:0] ALU_FADD   = 4'b1100;
  localparam logic [3:0] ALU_FMUL   = 4'b0101;
  localparam logic [3:0] ALU_VADD   = 4'b1000;
  localparam logic [3:0] ALU_VADDFP = 4'b1100;
  localparam logic [3:0] ALU_VSUB   = 4'b1001;
  localparam logic [3:0] ALU_VAND   = 4'b1010;
  localparam logic [3:0] ALU_VORR   = 4'b1011;
  localparam logic [3:0] ALU_VXOR   = 4'b1111;
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [3:0] FUNCT_MOV    = 4'b1110;
  localparam logic [3:0] FUNCT_MOVIDX = 4'b1101;
  typedef enum logic {IDLE, EXEC} state_t;
  typedef struct packed {
    logic       regw, memw, memtoreg, alusrc, vecw, vecidxw, branch, aluop;
    logic       illegal, vbeat, movidx;
    logic [1:0] immsrc, regsrc;
    logic [3:0] alucontrol;
  } ctrl_t;
  function automatic logic [3:0] alu_map(input logic [3:0] f);
    case (f)
      4'b0101: return ALU_SUB;
      4'b0010: return ALU_AND;
      4'b0000: return ALU_ORR;
      4'b0011: return ALU_XOR;
      4'b0111: return ALU_FADD;
      4'b0110: return ALU_FMUL;
      4'b1000: return ALU_VADD;
      4'b1100: return ALU_VADDFP;
      4'b1001: return ALU_VSUB;
      4'b1010: return ALU_VAND;
      4'b1011: return ALU_VORR;
      4'b1111: return ALU_VXOR;
      default: return ALU_ADD;
    endcase
  endfunction
endpackage

// File: rtl/vdecode_seq_if.sv
// vdecode_seq_if: fetch handshake, instruction fields and datapath control word
interface vdecode_seq_if #(parameter int LW = 2);
  logic          instr_valid, instr_ready;
  logic [1:0]    Op;
  logic [5:0]    Funct;
  logic [3:0]    Rd;
  logic          RegW, MemW, MemtoReg, ALUSrc, VecW, VecIdxW, PCS, Done, Illegal;
  logic [1:0]    ImmSrc, RegSrc, FlagW;
  logic [3:0]    ALUControl;
  logic [LW-1:0] Lane;
  modport master (output instr_valid, Op, Funct, Rd,
                  input instr_ready, RegW, MemW, MemtoReg, ALUSrc, VecW, VecIdxW, PCS,
                  Done, Illegal, ImmSrc, RegSrc, FlagW, ALUControl, Lane);
  modport slave (input instr_valid, Op, Funct, Rd,
                 output instr_ready, RegW, MemW, MemtoReg, ALUSrc, VecW, VecIdxW, PCS,
                 Done, Illegal, ImmSrc, RegSrc, FlagW, ALUControl, Lane);
endinterface

// File: rtl/vdecode_seq_ctrl.sv
// vdec_ctrl: combinational map from held Op/Funct to control word, aluop and ALUControl
module vdec_ctrl
  import vdec_pkg::*;
(
  input  logic [1:0] op_i,
  input  logic [5:0] funct_i,
  output ctrl_t      ctrl_o
);
  logic [3:0] f;
  assign f = funct_i[4:1];
  always_comb begin
    ctrl_o = '0;
    case (op_i)
      OP_DP: begin
        if (f == FUNCT_MOVIDX) begin
          ctrl_o.vecidxw = 1'b1;
          ctrl_o.regsrc  = 2'b10;
          ctrl_o.movidx  = 1'b1;
        end else if (f == FUNCT_MOV) begin
          ctrl_o.regsrc = 2'b11;
          ctrl_o.alusrc = 1'b1;
          ctrl_o.regw   = 1'b1;
          ctrl_o.aluop  = 1'b1;
        end else begin
          ctrl_o.aluop  = 1'b1;
          ctrl_o.alusrc = funct_i[5];
          ctrl_o.vecw   = funct_i[4];
          ctrl_o.regw   = ~funct_i[4];
          ctrl_o.vbeat  = funct_i[4];
        end
      end
      OP_MEM: begin
        ctrl_o.immsrc   = 2'b01;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.memtoreg = funct_i[0];
        ctrl_o.regw     = funct_i[0];
        ctrl_o.memw     = ~funct_i[0];
        ctrl_o.regsrc   = funct_i[0] ? 2'b00 : 2'b10;
      end
      OP_BR: begin
        ctrl_o.immsrc = 2'b10;
        ctrl_o.alusrc = 1'b1;
        ctrl_o.branch = 1'b1;
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
    ctrl_o.alucontrol = ctrl_o.aluop ? alu_map(f) : ALU_ADD;
  end
endmodule

// File: rtl/vdecode_seq.sv
// vdecode_seq: latches one instruction and sequences its control word, splitting vector ops into lane beats
module vdecode_seq
  import vdec_pkg::*;
#(
  parameter int NLANES = 4,
  parameter int LW     = (NLANES > 1) ? $clog2(NLANES) : 1
) (
  input logic          clk,
  input logic          reset,
  vdecode_seq_if.slave bus
);
  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [5:0]    funct_q, funct_d;
  logic [3:0]    rd_q, rd_d;
  logic [LW-1:0] lane_q, lane_d;
  logic          exec, done, acc, flag_hi;
  ctrl_t         c;
  vdec_ctrl u_ctrl (.op_i(op_q), .funct_i(funct_q), .ctrl_o(c));
  assign exec            = state_q == EXEC;
  assign done            = exec & (~c.vbeat | lane_q == LW'(NLANES - 1));
  assign bus.instr_ready = ~exec | done;
  assign acc             = bus.instr_valid & bus.instr_ready;
  always_comb begin
    state_d = bus.instr_ready ? (acc ? EXEC : IDLE) : state_q;
    op_d    = acc ? bus.Op : op_q;
    funct_d = acc ? bus.Funct : funct_q;
    rd_d    = acc ? bus.Rd : rd_q;
    lane_d  = acc ? '0 : exec ? lane_q + 1'b1 : lane_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      funct_q <= '0;
      rd_q    <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      funct_q <= funct_d;
      rd_q    <= rd_d;
      lane_q  <= lane_d;
    end
  end
  // vector flag updates land only on the final lane so the whole vector sets flags once
  assign flag_hi        = exec & funct_q[0] & c.aluop & (~c.vbeat | done);
  assign bus.FlagW      = {flag_hi, flag_hi & (c.alucontrol == ALU_ADD | c.alucontrol == ALU_SUB)};
  assign bus.RegW       = exec & c.regw;
  assign bus.MemW       = exec & c.memw;
  assign bus.MemtoReg   = exec & c.memtoreg;
  assign bus.ALUSrc     = exec & c.alusrc;
  assign bus.VecW       = exec & c.vecw;
  assign bus.VecIdxW    = exec & c.vecidxw;
  assign bus.ImmSrc     = exec ? c.immsrc : 2'b00;
  assign bus.RegSrc     = exec ? c.regsrc : 2'b00;
  assign bus.ALUControl = exec ? c.alucontrol : ALU_ADD;
  assign bus.PCS        = done & ((rd_q == 4'hF & c.regw) | c.branch);
  assign bus.Done       = done;
  assign bus.Illegal    = exec & c.illegal;
  assign bus.Lane       = ~exec ? '0 : c.movidx ? rd_q[LW-1:0] : lane_q;
endmodule

// File: doc/vdecode_seq.md
# vdecode_seq

Sequenced successor of the single-cycle instruction decoder: it latches one instruction's Op/Funct/Rd, then drives the datapath control word over one or more cycles. Vector data-processing instructions are split into per-lane beats across a parametrised lane count. It sits between instruction fetch and the register file, ALU and vector file. It stalls fetch through a valid/ready handshake while a vector instruction is in progress.

## Interface
- NLANES, default 4: vector lanes per instruction; power of two, 1 to 16.
- LW, default $clog2(NLANES) (minimum 1): lane-index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; returns the block to IDLE immediately.
- instr_valid  in  1  fetch presents an instruction.
- instr_ready  out  1  decoder accepts this cycle.
- Op  in  2, Funct  in  6, Rd  in  4  instruction fields; sampled only on acceptance.
- RegW, MemW, MemtoReg, ALUSrc, VecW, VecIdxW, PCS  out  1 each  datapath enables.
- ImmSrc, RegSrc  out  2 each;  FlagW  out  2;  ALUControl  out  4.
- Lane  out  LW  active lane index.
- Done  out  1  final cycle of the current instruction.
- Illegal  out  1  Op=11 was decoded.

## Operation
- States:
  - IDLE: no instruction held.
  - EXEC: an instruction is held.
- Acceptance: `acc = instr_valid & instr_ready`.
  - On acc, capture Op/Funct/Rd into holding registers, clear the lane counter and enter EXEC.
- `instr_ready = (state==IDLE) | (state==EXEC & Done)`, which allows back-to-back issue.
- Classification of the held instruction:
  - **Vector beat-op:** Op=00, Funct[4]=1, and Funct[4:1] not in {1101, 1110}. Takes NLANES beats.
  - **Everything else:** one beat.
- Lane counter increments each EXEC cycle.
- `Done = (state==EXEC) & (single-beat | Lane==NLANES-1)`.
- At Done, the next state is EXEC if acc, else IDLE.
- Control word (RegW, MemW, MemtoReg, ALUSrc, ImmSrc, RegSrc, VecW, VecIdxW, branch, aluop) by class:
  - DP register, Op=00, Funct[5]=0, Funct[4]=0: RegW, aluop.
  - Vec-vec, Op=00, Funct[5]=0, Funct[4]=1: VecW, aluop.
  - DP immediate, Op=00, Funct[5]=1, Funct[4]=0: ALUSrc, RegW, aluop.
  - Vec-imm, Op=00, Funct[5]=1, Funct[4]=1, excluding 1101/1110: VecW, ALUSrc, aluop.
  - MOV-to-reg, Funct[4:1]=1110: RegSrc=11, ALUSrc, RegW, aluop.
  - MOVIDX, Funct[4:1]=1101: VecIdxW, RegSrc=10, ImmSrc=00; one beat. Lane is driven by Rd[LW-1:0].
  - LDR, Op=01 and Funct[0]=1: ImmSrc=01, ALUSrc, MemtoReg, RegW.
  - STR, Op=01 and Funct[0]=0: RegSrc=10, ImmSrc=01, ALUSrc, MemW.
  - B, Op=10: ImmSrc=10, ALUSrc, branch.
  - Op=11: all enables 0 and Illegal=1 for one beat.
- ALUControl when aluop is set, indexed by Funct[4:1]:
  - 1110→0000, 0100→0000, 0101→0001, 0010→0010, 0000→0011, 0011→0111, 0111→1100, 0110→0101.
  - 1000→1000, 1100→1100, 1001→1001, 1010→1010, 1011→1011, 1111→1111.
  - Any other value→0000.
  - When aluop is clear, ALUControl=0000.
- FlagW:
  - FlagW[1] = Funct[0] & aluop.
  - FlagW[0] = FlagW[1] & (ALUControl ∈ {0000, 0001}).
  - For a vector beat-op, both bits are forced to 0 except on the Done beat.
- `PCS = ((Rd==1111) & RegW) | branch`, asserted only on the Done beat.
- In IDLE, every enable, FlagW, PCS, Done and Illegal is 0; Lane is 0; ALUControl is 0000.

## Timing
- Reset values: state IDLE, Lane 0, holding registers 0. All outputs are at their IDLE values and instr_ready is 1.
- Outputs are combinational from state, the holding registers and Lane. They are valid during the EXEC cycle following acceptance.
- Latency: acceptance at edge k puts the first beat in cycle k+1.
- Occupancy: scalar and MOVIDX take 1 cycle; a vector beat-op takes NLANES cycles, with Lane running 0 to NLANES-1.
- Sustained throughput: 1 instruction/cycle for scalar streams.
- NLANES=1: vector ops take a single beat with Lane=0, and FlagW is enabled on that beat.
- instr_valid while busy (not Done): ignored; fetch must hold the instruction.
- Reset asserted mid-vector: return to IDLE asynchronously. No further enables are driven and the partial instruction is discarded.
- Lane wraps to 0 only through a new acceptance.

## Structure
- `vdec_pkg` holds:
  - the ALUControl encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_XOR, ALU_FADD, ALU_FMUL, ALU_VADD, ALU_VADDFP, ALU_VSUB, ALU_VAND, ALU_VORR, ALU_VXOR);
  - the Op codes OP_DP, OP_MEM, OP_BR;
  - the FUNCT_MOV and FUNCT_MOVIDX constants;
  - the state enum {IDLE, EXEC}.
- One combinational sub-module, `vdec_ctrl`, maps the held Op/Funct to the control word, aluop and ALUControl.
- The top level holds the FSM, lane counter, holding registers, FlagW/PCS gating and the handshake.

## Test plan
- **Scalar ADD with S:** after reset, Op=00, Funct=001001, Rd=0011. The next cycle shows RegW=1, ALUControl=0000, FlagW=11, Done=1, instr_ready=1.
- **VADD at NLANES=4:** Op=00, Funct=010000. Expect 4 cycles with VecW=1 and Lane=0,1,2,3. Done=1 only at Lane=3 and instr_ready=0 for the first 3 beats. An ADD held valid is accepted at Lane 3.
- **Flag gating on VSUB:** VSUB with S (Funct=010011). FlagW=00 on beats 0-2; FlagW=10 (ALUControl=1001) on beat 3 only.
- **MOVIDX:** Funct=111010, Rd=0110, NLANES=4. One beat with VecIdxW=1, Lane=2, VecW=0, Done=1.
- **Branch, PC write and illegal:** B gives PCS=1 with ImmSrc=10. LDR with Rd=1111 gives PCS=1 and MemtoReg=1. Op=11 gives Illegal=1 with all enables 0.
- **Reset mid-vector:** assert reset during VADD at Lane=1. Outputs return to IDLE values the same cycle and instr_ready=1 after release.
